// File: rtl/ttl_debounce_multi.sv
// Multi-channel glitch filter for asynchronous TTL pins: per-channel synchronizer and saturating
// counter, consecutive/integrate modes, edge strobes and a shared rejected-glitch counter.
module ttl_debounce_multi #(
  parameter int CH          = 4,
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    ttl_in,
  input  logic [CNT_W-1:0] filt_len,
  input  logic             mode,
  input  logic             glitch_clr,
  output logic [CH-1:0]    ttl_out,
  output logic [CH-1:0]    rise_pulse,
  output logic [CH-1:0]    fall_pulse,
  output logic [CH-1:0]    busy,
  output logic [15:0]      glitch_cnt
);

  localparam int CW1   = CNT_W + 1;
  localparam int POP_W = $clog2(CH + 1);

  function automatic logic [POP_W-1:0] count_ones(input logic [CH-1:0] v);
    logic [POP_W-1:0] n;
    n = POP_W'(0);
    for (int k = 0; k < CH; k++) begin
      n = n + POP_W'(v[k]);
    end
    return n;
  endfunction

  logic [CH-1:0]    sync_r [SYNC_STAGES];
  logic [CH-1:0]    s_s;
  logic             mode_r;
  logic             mode_chg_s;
  logic [CNT_W-1:0] neff_s;
  logic [CNT_W-1:0] cnt_r     [CH];
  logic [CNT_W-1:0] cnt_nxt_s [CH];
  logic [CH-1:0]    out_nxt_s;
  logic [CH-1:0]    busy_nxt_s;
  logic [CH-1:0]    reject_s;
  logic [16:0]      gsum_s;

  // Input synchronizer chain per channel
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {CH{1'b0}};
      end
    end else begin
      sync_r[0] <= ttl_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign s_s        = sync_r[SYNC_STAGES-1];
  assign neff_s     = (filt_len == CNT_W'(0)) ? CNT_W'(1) : filt_len;
  assign mode_chg_s = mode ^ mode_r;

  // Next counter/level per channel; thresholds use >= so a shrinking length never strands a count
  always_comb begin
    logic [CW1-1:0]   inc;
    logic [CNT_W-1:0] idle;
    for (int i = 0; i < CH; i++) begin
      inc           = {1'b0, cnt_r[i]} + CW1'(1);
      cnt_nxt_s[i]  = cnt_r[i];
      out_nxt_s[i]  = ttl_out[i];
      reject_s[i]   = 1'b0;
      if (mode_chg_s) begin
        if (mode && ttl_out[i]) begin
          cnt_nxt_s[i] = neff_s;
        end else begin
          cnt_nxt_s[i] = CNT_W'(0);
        end
      end else if (!mode_r) begin
        if (s_s[i] == ttl_out[i]) begin
          cnt_nxt_s[i] = CNT_W'(0);
          reject_s[i]  = (cnt_r[i] != CNT_W'(0));
        end else if (inc >= {1'b0, neff_s}) begin
          cnt_nxt_s[i] = CNT_W'(0);
          out_nxt_s[i] = ~ttl_out[i];
        end else begin
          cnt_nxt_s[i] = inc[CNT_W-1:0];
        end
      end else if (s_s[i]) begin
        if (inc >= {1'b0, neff_s}) begin
          cnt_nxt_s[i] = neff_s;
        end else begin
          cnt_nxt_s[i] = inc[CNT_W-1:0];
        end
        if (cnt_nxt_s[i] == neff_s) begin
          out_nxt_s[i] = 1'b1;
        end else begin
          out_nxt_s[i] = ttl_out[i];
        end
      end else begin
        if (cnt_r[i] > neff_s) begin
          cnt_nxt_s[i] = neff_s - CNT_W'(1);
        end else if (cnt_r[i] != CNT_W'(0)) begin
          cnt_nxt_s[i] = cnt_r[i] - CNT_W'(1);
        end else begin
          cnt_nxt_s[i] = CNT_W'(0);
        end
        if (cnt_nxt_s[i] == CNT_W'(0)) begin
          out_nxt_s[i] = 1'b0;
        end else begin
          out_nxt_s[i] = ttl_out[i];
        end
      end
      // Idle value follows the mode that will be in force after this edge
      if (mode && out_nxt_s[i]) begin
        idle = neff_s;
      end else begin
        idle = CNT_W'(0);
      end
      busy_nxt_s[i] = (cnt_nxt_s[i] != idle);
    end
  end

  // Filter state, levels and strobes
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r     <= 1'b0;
      ttl_out    <= {CH{1'b0}};
      rise_pulse <= {CH{1'b0}};
      fall_pulse <= {CH{1'b0}};
      busy       <= {CH{1'b0}};
      for (int i = 0; i < CH; i++) begin
        cnt_r[i] <= CNT_W'(0);
      end
    end else begin
      mode_r     <= mode;
      ttl_out    <= out_nxt_s;
      rise_pulse <= out_nxt_s & ~ttl_out;
      fall_pulse <= ~out_nxt_s & ttl_out;
      busy       <= busy_nxt_s;
      for (int i = 0; i < CH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign gsum_s = {1'b0, glitch_cnt} + 17'(count_ones(reject_s));

  // Saturating rejected-glitch counter; clear wins over same-cycle increments
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= 16'h0000;
    end else if (glitch_clr) begin
      glitch_cnt <= 16'h0000;
    end else if (gsum_s > 17'h0FFFF) begin
      glitch_cnt <= 16'hFFFF;
    end else begin
      glitch_cnt <= gsum_s[15:0];
    end
  end

endmodule

// File: tb/tb_ttl_debounce_multi.sv
// Bench for ttl_debounce_multi: directed latency/glitch/saturation/reset sequences, an
// integrate-mode vector table, and random traffic against a behavioural reference model.
module tb_ttl_debounce_multi;
  localparam int CH    = 4;
  localparam int CNT_W = 6;
  localparam int SS    = 2;

  logic             sys_clk = 1'b0;
  logic             rst_n;
  logic [CH-1:0]    ttl_in;
  logic [CNT_W-1:0] filt_len;
  logic             mode;
  logic             glitch_clr;
  logic [CH-1:0]    ttl_out;
  logic [CH-1:0]    rise_pulse;
  logic [CH-1:0]    fall_pulse;
  logic [CH-1:0]    busy;
  logic [15:0]      glitch_cnt;

  int checks   = 0;
  int failures = 0;

  ttl_debounce_multi #(.CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .ttl_in     (ttl_in),
    .filt_len   (filt_len),
    .mode       (mode),
    .glitch_clr (glitch_clr),
    .ttl_out    (ttl_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy),
    .glitch_cnt (glitch_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model state: integer counters, pin history queue (index 0 = newest sample)
  int            m_cnt [CH];
  logic [CH-1:0] m_out, m_rise, m_fall, m_busy;
  int            m_g;
  logic          m_mode;
  logic [CH-1:0] m_pipe [$];

  task automatic model_reset();
    for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    m_out = '0; m_rise = '0; m_fall = '0; m_busy = '0;
    m_g = 0; m_mode = 1'b0;
    m_pipe.delete();
    for (int k = 0; k < SS; k++) m_pipe.push_back('0);
  endtask

  task automatic model_edge();
    int n;
    int rej;
    logic [CH-1:0] s;
    logic [CH-1:0] prev;
    bit chg;
    n    = (filt_len == 0) ? 1 : int'(filt_len);
    s    = m_pipe[SS-1];
    chg  = (mode != m_mode);
    prev = m_out;
    rej  = 0;
    for (int i = 0; i < CH; i++) begin
      if (chg) begin
        m_cnt[i] = (mode && m_out[i]) ? n : 0;
      end else if (!m_mode) begin
        if (s[i] == m_out[i]) begin
          if (m_cnt[i] > 0) rej++;
          m_cnt[i] = 0;
        end else if (m_cnt[i] + 1 >= n) begin
          m_out[i] = ~m_out[i];
          m_cnt[i] = 0;
        end else begin
          m_cnt[i]++;
        end
      end else if (s[i]) begin
        m_cnt[i] = (m_cnt[i] + 1 > n) ? n : m_cnt[i] + 1;
        if (m_cnt[i] == n) m_out[i] = 1'b1;
      end else begin
        if (m_cnt[i] > n) m_cnt[i] = n - 1;
        else if (m_cnt[i] > 0) m_cnt[i]--;
        if (m_cnt[i] == 0) m_out[i] = 1'b0;
      end
      m_busy[i] = (m_cnt[i] != ((mode && m_out[i]) ? n : 0));
    end
    m_rise = m_out & ~prev;
    m_fall = ~m_out & prev;
    m_mode = mode;
    if (glitch_clr) m_g = 0;
    else m_g = (m_g + rej > 65535) ? 65535 : m_g + rej;
    m_pipe.push_front(ttl_in);
    void'(m_pipe.pop_back());
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      if (rst_n) model_edge();
      @(posedge sys_clk);
      #1;
      chk("model", {ttl_out, rise_pulse, fall_pulse, busy, glitch_cnt},
          {m_out, m_rise, m_fall, m_busy, m_g[15:0]});
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_clear", {ttl_out, rise_pulse, fall_pulse, busy, glitch_cnt}, 64'd0);
    step(2);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       pin;
    logic [3:0] exp;  // {ttl_out, rise_pulse, fall_pulse, busy} of channel 0
  } vec_t;

  vec_t tbl [15];

  initial begin
    int first;
    int rises;
    int seen;
    int jump_edge;
    int jump_size;
    logic [15:0] g_prev;

    tbl[0]  = '{1'b1, 4'b0000}; tbl[1]  = '{1'b1, 4'b0000}; tbl[2]  = '{1'b0, 4'b0001};
    tbl[3]  = '{1'b1, 4'b0001}; tbl[4]  = '{1'b1, 4'b0001}; tbl[5]  = '{1'b1, 4'b0001};
    tbl[6]  = '{1'b0, 4'b0001}; tbl[7]  = '{1'b0, 4'b1100}; tbl[8]  = '{1'b1, 4'b1001};
    tbl[9]  = '{1'b0, 4'b1001}; tbl[10] = '{1'b0, 4'b1001}; tbl[11] = '{1'b0, 4'b1001};
    tbl[12] = '{1'b0, 4'b1001}; tbl[13] = '{1'b0, 4'b0010}; tbl[14] = '{1'b0, 4'b0000};

    rst_n = 1'b1; ttl_in = '0; filt_len = 6'd8; mode = 1'b0; glitch_clr = 1'b0;
    model_reset();
    #1;
    apply_reset();

    // Consecutive step, N=8: rise at edge SS+8 = 10, exactly one strobe
    ttl_in = 4'b0001;
    first = 0; rises = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (rise_pulse[0] && first == 0) first = k;
      rises += int'(rise_pulse[0]);
    end
    chk("consec_rise_edge", first, 10);
    chk("consec_rise_count", rises, 1);
    chk("consec_level", ttl_out[0], 1'b1);

    // 7-cycle pulse on ch1 is rejected and counted once
    seen = 0;
    ttl_in[1] = 1'b1;
    for (int k = 0; k < 7; k++) begin step(); seen += int'(ttl_out[1]); end
    ttl_in[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin step(); seen += int'(ttl_out[1]); end
    chk("glitch7_no_output", seen, 0);
    chk("glitch7_count", glitch_cnt, 16'd1);

    // Simultaneous 3-cycle pulses on all channels, N=5: +4 in one cycle at edge 6
    ttl_in = '0; filt_len = 6'd5;
    apply_reset();
    jump_edge = 0; jump_size = 0; g_prev = glitch_cnt;
    for (int k = 1; k <= 13; k++) begin
      ttl_in = (k <= 3) ? 4'hF : 4'h0;
      step();
      if (glitch_cnt != g_prev) begin jump_edge = k; jump_size = int'(glitch_cnt - g_prev); end
      g_prev = glitch_cnt;
    end
    chk("simul_jump_edge", jump_edge, 6);
    chk("simul_jump_size", jump_size, 4);
    chk("simul_total", glitch_cnt, 16'd4);

    // glitch_clr on the increment edge wins
    ttl_in = 4'hF; step(3);
    ttl_in = 4'h0; step(2);
    glitch_clr = 1'b1; step(); glitch_clr = 1'b0;
    chk("clr_priority", glitch_cnt, 16'd0);
    step(5);
    chk("clr_hold", glitch_cnt, 16'd0);

    // Preload to 0xFFFE with 1-cycle glitches at N=2, then saturate
    filt_len = 6'd2;
    for (int k = 0; k < 16383; k++) begin
      ttl_in = 4'hF; step();
      ttl_in = 4'h0; step();
    end
    for (int k = 0; k < 2; k++) begin
      ttl_in = 4'h1; step();
      ttl_in = 4'h0; step();
    end
    step(4);
    chk("preload", glitch_cnt, 16'hFFFE);
    filt_len = 6'd5;
    ttl_in = 4'hF; step(3);
    ttl_in = 4'h0; step(9);
    chk("saturate", glitch_cnt, 16'hFFFF);

    // filt_len=0 behaves as N=1
    ttl_in = '0; filt_len = 6'd0;
    apply_reset();
    ttl_in = 4'b0100;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (rise_pulse[2] && first == 0) first = k;
    end
    chk("len0_rise_edge", first, 3);

    // Mode switch with ch2 high and a consecutive count pending
    filt_len = 6'd8;
    ttl_in[2] = 1'b0;
    step(5);
    chk("switch_pending", {ttl_out[2], busy[2]}, 2'b11);
    mode = 1'b1;
    step();
    chk("switch_edge", {ttl_out[2], busy[2], rise_pulse[2], fall_pulse[2]}, 4'b1000);
    ttl_in[2] = 1'b1;
    step(3);

    // Integrate hysteresis table, N=4
    ttl_in = '0; filt_len = 6'd4; mode = 1'b1;
    apply_reset();
    step();
    for (int j = 0; j < 15; j++) begin
      ttl_in[0] = tbl[j].pin;
      step();
      chk("integ_table", {ttl_out[0], rise_pulse[0], fall_pulse[0], busy[0]}, tbl[j].exp);
    end

    // Integrate: cnt=10 with N=12, then N lowered to 6 with s=1
    filt_len = 6'd12;
    ttl_in[3] = 1'b1;
    step(12);
    chk("lower_n_before", {ttl_out[3], busy[3]}, 2'b01);
    filt_len = 6'd6;
    step();
    chk("lower_n_after", {ttl_out[3], rise_pulse[3], busy[3]}, 3'b110);

    // Async reset with a consecutive count at 5 of 8, pin held high through release
    ttl_in = '0; filt_len = 6'd8; mode = 1'b0;
    apply_reset();
    ttl_in[0] = 1'b1;
    step(7);
    chk("midreset_pending", busy[0], 1'b1);
    #2;
    apply_reset();
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (rise_pulse[0] && first == 0) first = k;
    end
    chk("midreset_rise_edge", first, 10);

    // Random traffic against the model
    ttl_in = '0; filt_len = 6'd3; mode = 1'b0;
    apply_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0) ttl_in[i] = ~ttl_in[i];
      end
      if ($urandom_range(0, 150) == 0) filt_len = CNT_W'($urandom_range(0, 7));
      if ($urandom_range(0, 400) == 0) mode = ~mode;
      glitch_clr = ($urandom_range(0, 199) == 0);
      step();
    end
    glitch_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
